sram_sp_ctrl: RTL and testbench

//  Access controller sitting directly upstream of a single-port SRAM macro (CEB/WEB/A/D/Q, 1-cycle read).

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_init_sweep.sv | 56 +++++
 rtl/sram_sp_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_sp_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the single-port SRAM access controller.
//   ctrl_state_e : controller FSM states (zero sweep, normal operation)
//   addr_w_f     : address width helper for a given word depth
//   CEB_IDLE / WEB_IDLE : macro pin levels for a cycle with no access
package sram_ctrl_pkg;

   typedef enum logic {
      INIT = 1'b0,
      IDLE = 1'b1
   } ctrl_state_e;

   localparam logic CEB_IDLE = 1'b1;
   localparam logic WEB_IDLE = 1'b1;

   // A depth of 1 still needs a 1-bit address.
   function automatic int unsigned addr_w_f(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sram_init_sweep.sv
// Post-reset zero sweep sequencer.
//   CLK, RSTB : clock, async active-low reset
//   state     : controller state, INIT until the last word has been written
//   init_cnt  : address of the word being zeroed this cycle
//   init_done : registered, high from the cycle after the last sweep write
module sram_init_sweep
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = addr_w_f(DEPTH)
) (
   input  logic              CLK,
   input  logic              RSTB,
   output ctrl_state_e       state,
   output logic [ADDR_W-1:0] init_cnt,
   output logic              init_done
);

   ctrl_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q <= INIT;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      unique case (state_q)
         INIT: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         IDLE: ;  // terminal until reset
         default: state_d = INIT;
      endcase
   end

   assign state     = state_q;
   assign init_cnt  = cnt_q;
   assign init_done = done_q;

endmodule

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM access controller.
// Merges a read and a write request channel onto one macro port (write priority, reads forced
// ahead after STARVE_LIM blocked cycles), zeroes the array after reset, and holds read data
// between responses because the macro Q is undefined on non-read cycles.
//   CLK, RSTB                          : clock, async active-low reset
//   rreq_valid/ready/addr              : read request channel
//   wreq_valid/ready/addr/data         : write request channel
//   rresp_valid, rresp_data            : read response, one cycle after read fire
//   init_done                          : zero sweep complete
//   sram_ceb/web/a/d, sram_q           : macro pins (1-cycle read latency)
module sram_sp_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_W     = addr_w_f(DEPTH),
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic              CLK,
   input  logic              RSTB,
   input  logic              rreq_valid,
   output logic              rreq_ready,
   input  logic [ADDR_W-1:0] rreq_addr,
   input  logic              wreq_valid,
   output logic              wreq_ready,
   input  logic [ADDR_W-1:0] wreq_addr,
   input  logic [DATA_W-1:0] wreq_data,
   output logic              rresp_valid,
   output logic [DATA_W-1:0] rresp_data,
   output logic              init_done,
   output logic              sram_ceb,
   output logic              sram_web,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_d,
   input  logic [DATA_W-1:0] sram_q
);

   localparam int unsigned SW = $clog2(STARVE_LIM + 1);

   ctrl_state_e       state;
   logic [ADDR_W-1:0] init_cnt;

   sram_init_sweep #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_sweep (
      .CLK       (CLK),
      .RSTB      (RSTB),
      .state     (state),
      .init_cnt  (init_cnt),
      .init_done (init_done)
   );

   logic [SW-1:0]     starve_q, starve_d;
   logic              rvld_q;
   logic [DATA_W-1:0] rdata_q;
   logic              force_rd, w_fire, r_fire;

   assign force_rd = (starve_q == SW'(STARVE_LIM));

   always_comb begin
      rreq_ready = 1'b0;
      wreq_ready = 1'b0;
      w_fire     = 1'b0;
      r_fire     = 1'b0;
      sram_ceb   = CEB_IDLE;
      sram_web   = WEB_IDLE;
      sram_a     = '0;
      sram_d     = '0;
      unique case (state)
         INIT: begin
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = init_cnt;
         end
         IDLE: begin
            wreq_ready = !(force_rd && rreq_valid);
            rreq_ready = !wreq_valid || force_rd;
            w_fire     = wreq_valid && wreq_ready;
            // Ready terms already make the fires exclusive; the gate keeps it explicit.
            r_fire     = rreq_valid && rreq_ready && !w_fire;
            if (w_fire) begin
               sram_ceb = 1'b0;
               sram_web = 1'b0;
               sram_a   = wreq_addr;
               sram_d   = wreq_data;
            end else if (r_fire) begin
               sram_ceb = 1'b0;
               sram_a   = rreq_addr;
            end
         end
         default: ;
      endcase
      // Keep the macro deselected while reset is asserted, independent of FSM state.
      if (!RSTB) begin
         sram_ceb = CEB_IDLE;
         sram_web = WEB_IDLE;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!rreq_valid || r_fire) begin
         starve_d = '0;
      end else if (!rreq_ready && !force_rd) begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         starve_q <= '0;
         rvld_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         starve_q <= starve_d;
         rvld_q   <= r_fire;
         if (rvld_q) begin
            rdata_q <= sram_q;
         end
      end
   end

   // Q is only meaningful in the response cycle; afterwards the captured copy is shown.
   assign rresp_valid = rvld_q;
   assign rresp_data  = rvld_q ? sram_q : rdata_q;

endmodule

// File: tb/tb_sram_sp_ctrl.sv
module tb_sram_sp_ctrl;

   localparam int unsigned DATA_W     = 64;
   localparam int unsigned DEPTH      = 64;
   localparam int unsigned ADDR_W     = 6;
   localparam int unsigned STARVE_LIM = 4;
   localparam logic [DATA_W-1:0] JUNK = 64'hBADC_0FFE_E0DD_F00D;

   logic              CLK = 1'b0;
   logic              RSTB = 1'b0;
   logic              rreq_valid = 1'b0;
   logic              rreq_ready;
   logic [ADDR_W-1:0] rreq_addr = '0;
   logic              wreq_valid = 1'b0;
   logic              wreq_ready;
   logic [ADDR_W-1:0] wreq_addr = '0;
   logic [DATA_W-1:0] wreq_data = '0;
   logic              rresp_valid;
   logic [DATA_W-1:0] rresp_data;
   logic              init_done;
   logic              sram_ceb;
   logic              sram_web;
   logic [ADDR_W-1:0] sram_a;
   logic [DATA_W-1:0] sram_d;
   logic [DATA_W-1:0] sram_q = '0;

   int n_checks = 0;
   int n_errors = 0;

   sram_sp_ctrl #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .CLK         (CLK),
      .RSTB        (RSTB),
      .rreq_valid  (rreq_valid),
      .rreq_ready  (rreq_ready),
      .rreq_addr   (rreq_addr),
      .wreq_valid  (wreq_valid),
      .wreq_ready  (wreq_ready),
      .wreq_addr   (wreq_addr),
      .wreq_data   (wreq_data),
      .rresp_valid (rresp_valid),
      .rresp_data  (rresp_data),
      .init_done   (init_done),
      .sram_ceb    (sram_ceb),
      .sram_web    (sram_web),
      .sram_a      (sram_a),
      .sram_d      (sram_d),
      .sram_q      (sram_q)
   );

   always #5 CLK = ~CLK;

   // Macro model: 1-cycle read, Q is junk on every cycle that is not a read.
   logic [DATA_W-1:0] mem [DEPTH];
   initial begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
   end
   always @(posedge CLK) begin
      if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
      if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
      else sram_q <= JUNK;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      wreq_valid = 1'b1;
      wreq_addr  = addr;
      wreq_data  = data;
      #1;
      chk("wr_ready", 64'(wreq_ready), 64'd1);
      tick();
      wreq_valid = 1'b0;
   endtask

   // Release reset and check the full zero sweep, then init_done.
   task automatic release_and_sweep(input string tag);
      @(negedge CLK);
      RSTB = 1'b1;
      #1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (i > 0) tick();
         chk(tag, 64'({sram_ceb, sram_web, rreq_ready, wreq_ready, init_done, (sram_d != '0),
                       sram_a}), 64'({6'b0, 6'(i)}));
      end
      tick();
      chk({tag, "_done"}, 64'(init_done), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #2;
      chk("rst_done", 64'(init_done), 64'd0);
      chk("rst_rvalid", 64'(rresp_valid), 64'd0);
      chk("rst_rdata", rresp_data, 64'd0);
      chk("rst_pins", 64'({sram_ceb, sram_web}), 64'd3);
      repeat (2) tick();

      // T1: sweep after reset
      release_and_sweep("t1_sweep");
      chk("t1_idle_ceb", 64'(sram_ceb), 64'd1);

      // T2: write then read @5, then hold
      wreq_valid = 1'b1;
      wreq_addr  = 6'd5;
      wreq_data  = 64'hDEAD_BEEF_CAFE_F00D;
      #1;
      chk("t2_wpins", 64'({wreq_ready, sram_ceb, sram_web, sram_a}), 64'({3'b100, 6'd5}));
      chk("t2_wd", sram_d, 64'hDEAD_BEEF_CAFE_F00D);
      tick();
      wreq_valid = 1'b0;
      rreq_valid = 1'b1;
      rreq_addr  = 6'd5;
      #1;
      chk("t2_rpins", 64'({rreq_ready, sram_ceb, sram_web, sram_a}), 64'({3'b101, 6'd5}));
      chk("t2_rd0", sram_d, 64'd0);
      tick();
      rreq_valid = 1'b0;
      #1;
      chk("t2_rvalid", 64'(rresp_valid), 64'd1);
      chk("t2_rdata", rresp_data, 64'hDEAD_BEEF_CAFE_F00D);
      repeat (10) tick();
      chk("t2_hold_v", 64'(rresp_valid), 64'd0);
      chk("t2_hold_d", rresp_data, 64'hDEAD_BEEF_CAFE_F00D);

      // T3: same-address write and read in one cycle
      wreq_valid = 1'b1;
      wreq_addr  = 6'd3;
      wreq_data  = 64'h1;
      rreq_valid = 1'b1;
      rreq_addr  = 6'd3;
      #1;
      chk("t3_arb", 64'({wreq_ready, rreq_ready, sram_web}), 64'b100);
      tick();
      wreq_valid = 1'b0;
      #1;
      chk("t3_rd", 64'({rreq_ready, sram_ceb, sram_web, sram_a}), 64'({3'b101, 6'd3}));
      tick();
      rreq_valid = 1'b0;
      #1;
      chk("t3_resp", 64'({rresp_valid, rresp_data}), 64'({1'b1, 64'h1}));

      // T4: read starved by continuous writes
      do_write(6'd7, 64'h7777);
      for (int c = 1; c <= 8; c++) begin
         wreq_valid = 1'b1;
         wreq_addr  = 6'(10 + c);
         wreq_data  = 64'(c);
         rreq_valid = (c <= 5);
         rreq_addr  = 6'd7;
         #1;
         chk($sformatf("t4_rrdy_c%0d", c), 64'(rreq_ready), 64'(c == 5));
         chk($sformatf("t4_wrdy_c%0d", c), 64'(wreq_ready), 64'(c != 5));
         chk($sformatf("t4_web_c%0d", c), 64'(sram_web), 64'(c == 5));
         if (c == 6) chk("t4_resp", 64'({rresp_valid, rresp_data}), 64'({1'b1, 64'h7777}));
         tick();
      end
      wreq_valid = 1'b0;
      rreq_valid = 1'b0;

      // T6: unwritten word reads zero; back-to-back reads
      rreq_valid = 1'b1;
      rreq_addr  = 6'd63;
      tick();
      rreq_valid = 1'b0;
      #1;
      chk("t6_r63", 64'({rresp_valid, rresp_data}), 64'({1'b1, 64'h0}));
      for (int k = 0; k < 4; k++) do_write(6'(k), 64'h100 + 64'(k));
      for (int k = 0; k < 4; k++) begin
         rreq_valid = 1'b1;
         rreq_addr  = 6'(k);
         #1;
         chk($sformatf("t6_rrdy_%0d", k), 64'(rreq_ready), 64'd1);
         if (k > 0) chk($sformatf("t6_resp_%0d", k - 1), 64'({rresp_valid, rresp_data}),
                        64'({1'b1, 64'h100 + 64'(k - 1)}));
         tick();
      end
      rreq_valid = 1'b0;
      #1;
      chk("t6_resp_3", 64'({rresp_valid, rresp_data}), 64'({1'b1, 64'h103}));
      tick();
      chk("t6_end_v", 64'(rresp_valid), 64'd0);

      // T5: reset mid-read kills the response, then reset mid-sweep restarts it
      rreq_valid = 1'b1;
      rreq_addr  = 6'd0;
      tick();
      rreq_valid = 1'b0;
      #1;
      chk("t5_pend", 64'({rresp_valid, rresp_data}), 64'({1'b1, 64'h100}));
      RSTB = 1'b0;
      #1;
      chk("t5_kill", 64'({rresp_valid, rresp_data}), 64'd0);
      chk("t5_rst_pins", 64'({init_done, sram_ceb, sram_web}), 64'b011);
      @(negedge CLK);
      RSTB = 1'b1;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (sram_a == 6'd20) break;
      end
      chk("t5_at20", 64'({sram_ceb, sram_web, init_done, sram_a}), 64'({3'b000, 6'd20}));
      RSTB = 1'b0;
      #1;
      chk("t5_mid_pins", 64'({sram_ceb, sram_web}), 64'd3);
      wreq_valid = 1'b1;
      wreq_addr  = 6'd9;
      wreq_data  = 64'h99;
      release_and_sweep("t5_sweep");
      chk("t5_held_wr", 64'({wreq_ready, sram_ceb, sram_web, sram_a}), 64'({3'b100, 6'd9}));
      tick();
      wreq_valid = 1'b0;
      rreq_valid = 1'b1;
      rreq_addr  = 6'd9;
      tick();
      rreq_valid = 1'b0;
      #1;
      chk("t5_rd9", 64'({rresp_valid, rresp_data}), 64'({1'b1, 64'h99}));
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
